// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake plus FIFO write-port bundle for the shared write arbiter.
// The master modport is the arbiter's view; slave is the producers/FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int ID_W  = $clog2(NREQ)
) ();
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  fifo_full;
    logic                  fifo_wr_en;
    logic [WIDTH-1:0]      fifo_wr_data;
    logic [ID_W-1:0]       grant_id;
    logic                  busy;

    modport master (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );

    modport slave (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one synchronous FIFO write port between NREQ producers.
// A grant lasts until a last-flagged beat or MAX_BURST accepted beats, with one idle cycle between grants.
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 8,
    parameter int ID_W      = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    fifo_wr_arbiter_if.master bus
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NREQ - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BURST - 1);

    logic [0:0]       state_q,   state_d;
    logic [ID_W-1:0]  rrPtr_q,   rrPtr_d;
    logic [ID_W-1:0]  grantId_q, grantId_d;
    logic [CNT_W-1:0] beatCnt_q, beatCnt_d;

    logic             anyValid;
    logic [ID_W-1:0]  selIdx;
    logic             inBurst;
    logic             ownerValid;
    logic             ownerLast;
    logic [WIDTH-1:0] ownerData;
    logic [NREQ-1:0]  readyVec;
    logic             accept;
    logic             termBeat;

    // Lowest valid index at or after ptr wins; otherwise wrap to the lowest valid index overall.
    function automatic logic [ID_W-1:0] rrSelect(input logic [NREQ-1:0] valid,
                                                 input logic [ID_W-1:0] ptr);
        logic [ID_W-1:0] pickAny;
        logic [ID_W-1:0] pickUp;
        logic            hitUp;
        pickAny = '0;
        pickUp  = '0;
        hitUp   = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (valid[k]) begin
                pickAny = ID_W'(k);
                if (ID_W'(k) >= ptr) begin
                    pickUp = ID_W'(k);
                    hitUp  = 1'b1;
                end
            end
        end
        return hitUp ? pickUp : pickAny;
    endfunction

    assign anyValid = |bus.req_valid;
    assign selIdx   = rrSelect(bus.req_valid, rrPtr_q);

    // Owner signals are picked by a compare-mux so non-owner data can never leak to the FIFO.
    always_comb begin
        ownerValid = 1'b0;
        ownerLast  = 1'b0;
        ownerData  = '0;
        readyVec   = '0;
        inBurst    = (state_q == BURST) && !clr;
        for (int i = 0; i < NREQ; i++) begin
            if (grantId_q == ID_W'(i)) begin
                ownerValid  = bus.req_valid[i];
                ownerLast   = bus.req_last[i];
                ownerData   = bus.req_data[i*WIDTH +: WIDTH];
                readyVec[i] = inBurst && !bus.fifo_full;
            end
        end
        accept   = inBurst && ownerValid && !bus.fifo_full;
        termBeat = accept && (ownerLast || (beatCnt_q == CNT_LIMIT));
    end

    always_comb begin
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        grantId_d = grantId_q;
        beatCnt_d = beatCnt_q;
        if (state_q == IDLE) begin
            if (anyValid) begin
                state_d   = BURST;
                grantId_d = selIdx;
                beatCnt_d = '0;
            end
        end else if (accept) begin
            if (termBeat) begin
                state_d   = IDLE;
                beatCnt_d = '0;
                rrPtr_d   = (grantId_q == LAST_ID) ? '0 : grantId_q + 1'b1;
            end else begin
                beatCnt_d = beatCnt_q + 1'b1;
            end
        end
    end

    // clr shares the FIFO's clear net, so it restores exactly the reset image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            grantId_q <= '0;
            beatCnt_q <= '0;
        end else if (clr) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            grantId_q <= '0;
            beatCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            grantId_q <= grantId_d;
            beatCnt_q <= beatCnt_d;
        end
    end

    assign bus.req_ready    = readyVec;
    assign bus.fifo_wr_en   = accept;
    assign bus.fifo_wr_data = accept ? ownerData : '0;
    assign bus.grant_id     = grantId_q;
    assign bus.busy         = (state_q == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic against a
// transaction-level round-robin model built from per-producer beat streams.
module tb_fifo_wr_arbiter;
    localparam int WIDTH     = 8;
    localparam int NREQ      = 4;
    localparam int MAX_BURST = 8;
    localparam int DEPTH     = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    logic [WIDTH:0]   beatMem [NREQ][DEPTH];
    int               head [NREQ];
    int               tail [NREQ];
    logic [WIDTH-1:0] expData[$];
    logic [WIDTH-1:0] obsData[$];
    int               expOwn[$];
    int               obsOwn[$];
    int               expGrant[$];
    int               obsGrant[$];
    int               expLen[$];
    int               obsLen[$];
    int               protoErr;
    int               busyCycles;
    int               idleReq;
    bit               timedOut;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input int i, input logic v, input logic l, input logic [WIDTH-1:0] d);
        bus.req_valid[i]              = v;
        bus.req_last[i]               = l;
        bus.req_data[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic clearReq();
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
    endtask

    task automatic doReset();
        clearReq();
        bus.fifo_full = 1'b0;
        clr           = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
    endtask

    task automatic pushBeat(input int i, input logic [WIDTH-1:0] d, input logic l);
        beatMem[i][tail[i]] = {l, d};
        tail[i]++;
    endtask

    // Reference: pick the first producer with pending beats at/after the pointer, drain
    // its stream until a last flag, MAX_BURST beats or the stream end, then advance past it.
    task automatic buildExpected();
        int h [NREQ];
        int ptr;
        int o;
        int n;
        bit done;
        expData.delete(); expOwn.delete(); expGrant.delete(); expLen.delete();
        for (int i = 0; i < NREQ; i++) h[i] = head[i];
        ptr = 0;
        forever begin
            o = -1;
            for (int k = 0; k < NREQ; k++)
                if (o < 0 && h[(ptr + k) % NREQ] < tail[(ptr + k) % NREQ]) o = (ptr + k) % NREQ;
            if (o < 0) break;
            expGrant.push_back(o);
            n    = 0;
            done = 0;
            while (!done) begin
                expData.push_back(beatMem[o][h[o]][WIDTH-1:0]);
                expOwn.push_back(o);
                n++;
                done = beatMem[o][h[o]][WIDTH] || (n == MAX_BURST);
                h[o]++;
                if (h[o] == tail[o]) done = 1;
            end
            expLen.push_back(n);
            ptr = (o + 1) % NREQ;
        end
    endtask

    // Drives producers from their streams and records what the FIFO port actually saw.
    task automatic runTraffic(input int fullPct, input int gapPct, input int maxCycles);
        int cyc;
        bit prevBusy;
        int curLen;
        bit allEmpty;
        logic [NREQ-1:0] expReady;
        obsData.delete(); obsOwn.delete(); obsGrant.delete(); obsLen.delete();
        protoErr = 0; busyCycles = 0; idleReq = 0; timedOut = 0;
        prevBusy = 0; curLen = 0;
        for (cyc = 0; cyc < maxCycles; cyc++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                bit v;
                v = head[i] < tail[i];
                if (v && bus.busy && int'(bus.grant_id) == i && $urandom_range(99) < gapPct) v = 0;
                if (v) setReq(i, 1'b1, beatMem[i][head[i]][WIDTH], beatMem[i][head[i]][WIDTH-1:0]);
                else   setReq(i, 1'b0, 1'($urandom), WIDTH'($urandom));
            end
            bus.fifo_full = ($urandom_range(99) < fullPct);
            #1;
            if (bus.busy && !prevBusy) begin
                obsGrant.push_back(int'(bus.grant_id));
                curLen = 0;
            end
            if (!bus.busy && prevBusy) obsLen.push_back(curLen);
            if (bus.busy) busyCycles++;
            else if (|bus.req_valid) idleReq++;
            expReady = '0;
            if (bus.busy && !bus.fifo_full) expReady[bus.grant_id] = 1'b1;
            if (bus.req_ready !== expReady) protoErr++;
            if (bus.fifo_wr_en !== (bus.busy & bus.req_valid[bus.grant_id] & ~bus.fifo_full)) protoErr++;
            if (!bus.fifo_wr_en && bus.fifo_wr_data !== '0) protoErr++;
            if (bus.fifo_wr_en) begin
                obsData.push_back(bus.fifo_wr_data);
                obsOwn.push_back(int'(bus.grant_id));
                curLen++;
            end
            for (int i = 0; i < NREQ; i++)
                if (bus.req_valid[i] && bus.req_ready[i]) head[i]++;
            prevBusy = bus.busy;
            allEmpty = 1;
            for (int i = 0; i < NREQ; i++) if (head[i] < tail[i]) allEmpty = 0;
            if (allEmpty) break;
        end
        if (prevBusy && curLen > 0) obsLen.push_back(curLen);
        if (cyc >= maxCycles) timedOut = 1;
        clearReq();
        bus.fifo_full = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        bus.req_last  = '0;
        bus.req_data  = 32'hDEADBEEF;
        bus.fifo_full = 1'b0;
        #3;
        nCompared++; if (bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        nCompared++; if (bus.grant_id !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_grant: got %0d expected 0", bus.grant_id); end
        nCompared++; if (bus.fifo_wr_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_wr_en: got %b expected 0", bus.fifo_wr_en); end
        nCompared++; if (bus.fifo_wr_data !== 8'h00) begin nMismatched++; $display("[TB] FAIL reset_wr_data: got %h expected 00", bus.fifo_wr_data); end
        nCompared++; if (bus.req_ready !== 4'b0000) begin nMismatched++; $display("[TB] FAIL reset_ready: got %b expected 0000", bus.req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        step(); #1;
        nCompared++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_first_grant: got busy=%b id=%0d expected busy=1 id=0", bus.busy, bus.grant_id); end
        clearReq();
    endtask

    task automatic test_single();
        logic [7:0] beats [3];
        beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
        doReset();
        step(); setReq(2, 1'b1, 1'b0, beats[0]); #1;
        nCompared++; if (bus.busy !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_idle: got busy=%b wr_en=%b expected 0/0", bus.busy, bus.fifo_wr_en); end
        for (int b = 0; b < 3; b++) begin
            step();
            if (b > 0) setReq(2, 1'b1, (b == 2), beats[b]);
            #1;
            nCompared++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd2 || bus.req_ready !== 4'b0100) begin nMismatched++; $display("[TB] FAIL single_grant[%0d]: got busy=%b id=%0d ready=%b expected 1/2/0100", b, bus.busy, bus.grant_id, bus.req_ready); end
            nCompared++; if (bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== beats[b]) begin nMismatched++; $display("[TB] FAIL single_beat[%0d]: got wr_en=%b data=%h expected 1/%h", b, bus.fifo_wr_en, bus.fifo_wr_data, beats[b]); end
        end
        step(); setReq(2, 1'b0, 1'b0, 8'h00); #1;
        nCompared++; if (bus.busy !== 1'b0 || bus.grant_id !== 2'd2 || bus.fifo_wr_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL single_end: got busy=%b id=%0d wr_en=%b expected 0/2/0", bus.busy, bus.grant_id, bus.fifo_wr_en); end
        setReq(2, 1'b1, 1'b1, 8'hB2);
        setReq(3, 1'b1, 1'b1, 8'hB3);
        step(); #1;
        nCompared++; if (bus.grant_id !== 2'd3 || bus.fifo_wr_data !== 8'hB3) begin nMismatched++; $display("[TB] FAIL single_rr_ptr: got id=%0d data=%h expected 3/B3", bus.grant_id, bus.fifo_wr_data); end
        clearReq();
    endtask

    task automatic test_fairness();
        int perProd [NREQ];
        doReset();
        for (int i = 0; i < NREQ; i++)
            for (int b = 0; b < 6; b++) pushBeat(i, 8'(i * 16 + b), (b % 2) == 1);
        buildExpected();
        runTraffic(0, 0, 500);
        nCompared++; if (timedOut || protoErr != 0) begin nMismatched++; $display("[TB] FAIL fair_protocol: got timeout=%0b errors=%0d expected 0/0", timedOut, protoErr); end
        nCompared++; if (obsData.size() != expData.size()) begin nMismatched++; $display("[TB] FAIL fair_count: got %0d writes expected %0d", obsData.size(), expData.size()); end
        for (int k = 0; k < expData.size() && k < obsData.size(); k++) begin
            nCompared++; if (obsData[k] !== expData[k] || obsOwn[k] != expOwn[k]) begin nMismatched++; $display("[TB] FAIL fair_beat[%0d]: got %h/p%0d expected %h/p%0d", k, obsData[k], obsOwn[k], expData[k], expOwn[k]); end
        end
        nCompared++; if (obsGrant.size() != expGrant.size()) begin nMismatched++; $display("[TB] FAIL fair_grants: got %0d grants expected %0d", obsGrant.size(), expGrant.size()); end
        for (int k = 0; k < expGrant.size() && k < obsGrant.size(); k++) begin
            nCompared++; if (obsGrant[k] != expGrant[k]) begin nMismatched++; $display("[TB] FAIL fair_order[%0d]: got %0d expected %0d", k, obsGrant[k], expGrant[k]); end
        end
        for (int i = 0; i < NREQ; i++) perProd[i] = 0;
        foreach (obsOwn[k]) if (obsOwn[k] >= 0 && obsOwn[k] < NREQ) perProd[obsOwn[k]]++;
        for (int i = 0; i < NREQ; i++) begin
            nCompared++; if (perProd[i] != 6) begin nMismatched++; $display("[TB] FAIL fair_share[%0d]: got %0d writes expected 6", i, perProd[i]); end
        end
        nCompared++; if (busyCycles != expData.size() || idleReq != expGrant.size()) begin nMismatched++; $display("[TB] FAIL fair_throughput: got busy=%0d idle=%0d expected %0d/%0d", busyCycles, idleReq, expData.size(), expGrant.size()); end
    endtask

    task automatic test_burst_limit();
        doReset();
        for (int b = 0; b < 20; b++) pushBeat(1, 8'(8'h40 + b), 1'b0);
        buildExpected();
        runTraffic(0, 0, 500);
        nCompared++; if (timedOut || protoErr != 0) begin nMismatched++; $display("[TB] FAIL limit_protocol: got timeout=%0b errors=%0d expected 0/0", timedOut, protoErr); end
        nCompared++; if (obsData.size() != 20) begin nMismatched++; $display("[TB] FAIL limit_count: got %0d writes expected 20", obsData.size()); end
        for (int k = 0; k < expData.size() && k < obsData.size(); k++) begin
            nCompared++; if (obsData[k] !== expData[k] || obsOwn[k] != 1) begin nMismatched++; $display("[TB] FAIL limit_beat[%0d]: got %h/p%0d expected %h/p1", k, obsData[k], obsOwn[k], expData[k]); end
        end
        nCompared++; if (obsLen.size() != expLen.size()) begin nMismatched++; $display("[TB] FAIL limit_bursts: got %0d bursts expected %0d", obsLen.size(), expLen.size()); end
        for (int k = 0; k < expLen.size() && k < obsLen.size(); k++) begin
            nCompared++; if (obsLen[k] != expLen[k]) begin nMismatched++; $display("[TB] FAIL limit_len[%0d]: got %0d expected %0d", k, obsLen[k], expLen[k]); end
        end
    endtask

    task automatic test_backpressure();
        doReset();
        step(); setReq(0, 1'b1, 1'b0, 8'h10); #1;
        for (int b = 0; b < 8; b++) begin
            step();
            if (b > 0) setReq(0, 1'b1, 1'b0, 8'(8'h10 + b));
            if (b == 2) begin
                bus.fifo_full = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    if (s > 0) step();
                    #1;
                    nCompared++; if (bus.fifo_wr_en !== 1'b0 || bus.req_ready !== 4'b0000) begin nMismatched++; $display("[TB] FAIL bp_stall[%0d]: got wr_en=%b ready=%b expected 0/0000", s, bus.fifo_wr_en, bus.req_ready); end
                end
                step();
                bus.fifo_full = 1'b0;
            end
            #1;
            nCompared++; if (bus.busy !== 1'b1 || bus.fifo_wr_en !== 1'b1 || bus.fifo_wr_data !== 8'(8'h10 + b)) begin nMismatched++; $display("[TB] FAIL bp_beat[%0d]: got busy=%b wr_en=%b data=%h expected 1/1/%h", b, bus.busy, bus.fifo_wr_en, bus.fifo_wr_data, 8'(8'h10 + b)); end
        end
        step(); setReq(0, 1'b1, 1'b0, 8'h18); #1;
        nCompared++; if (bus.busy !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_burst_end: got busy=%b wr_en=%b expected 0/0", bus.busy, bus.fifo_wr_en); end
        step(); #1;
        nCompared++; if (bus.grant_id !== 2'd0 || bus.fifo_wr_data !== 8'h18) begin nMismatched++; $display("[TB] FAIL bp_resume: got id=%0d data=%h expected 0/18", bus.grant_id, bus.fifo_wr_data); end
        clearReq();
    endtask

    task automatic test_clear();
        doReset();
        step(); setReq(1, 1'b1, 1'b1, 8'h55); #1;
        step(); #1;
        step(); setReq(1, 1'b0, 1'b0, 8'h00); setReq(0, 1'b1, 1'b0, 8'h20); #1;
        for (int b = 0; b < 3; b++) begin
            step();
            if (b > 0) setReq(0, 1'b1, 1'b0, 8'(8'h20 + b));
            #1;
            nCompared++; if (bus.grant_id !== 2'd0 || bus.fifo_wr_data !== 8'(8'h20 + b)) begin nMismatched++; $display("[TB] FAIL clr_pre[%0d]: got id=%0d data=%h expected 0/%h", b, bus.grant_id, bus.fifo_wr_data, 8'(8'h20 + b)); end
        end
        step(); setReq(0, 1'b1, 1'b0, 8'h23); clr = 1'b1; #1;
        nCompared++; if (bus.fifo_wr_en !== 1'b0 || bus.req_ready !== 4'b0000) begin nMismatched++; $display("[TB] FAIL clr_gate: got wr_en=%b ready=%b expected 0/0000", bus.fifo_wr_en, bus.req_ready); end
        step(); clr = 1'b0; #1;
        nCompared++; if (bus.busy !== 1'b0 || bus.grant_id !== 2'd0) begin nMismatched++; $display("[TB] FAIL clr_state: got busy=%b id=%0d expected 0/0", bus.busy, bus.grant_id); end
        setReq(3, 1'b1, 1'b1, 8'h33);
        step(); #1;
        nCompared++; if (bus.grant_id !== 2'd0 || bus.fifo_wr_data !== 8'h23) begin nMismatched++; $display("[TB] FAIL clr_rearb: got id=%0d data=%h expected 0/23", bus.grant_id, bus.fifo_wr_data); end
        clearReq();
    endtask

    task automatic test_async_reset();
        doReset();
        step(); setReq(2, 1'b1, 1'b0, 8'h77); #1;
        step(); #1;
        nCompared++; if (bus.busy !== 1'b1 || bus.fifo_wr_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL areset_pre: got busy=%b wr_en=%b expected 1/1", bus.busy, bus.fifo_wr_en); end
        #1 rst_n = 1'b0;
        #1;
        nCompared++; if (bus.busy !== 1'b0 || bus.grant_id !== 2'd0 || bus.fifo_wr_en !== 1'b0 || bus.fifo_wr_data !== 8'h00 || bus.req_ready !== 4'b0000) begin
            nMismatched++; $display("[TB] FAIL areset_outputs: got busy=%b id=%0d wr_en=%b data=%h ready=%b expected all zero", bus.busy, bus.grant_id, bus.fifo_wr_en, bus.fifo_wr_data, bus.req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        setReq(2, 1'b0, 1'b0, 8'h00);
        setReq(1, 1'b1, 1'b1, 8'h31);
        setReq(3, 1'b1, 1'b1, 8'h33);
        step(); #1;
        nCompared++; if (bus.grant_id !== 2'd1 || bus.fifo_wr_data !== 8'h31) begin nMismatched++; $display("[TB] FAIL areset_rearb: got id=%0d data=%h expected 1/31", bus.grant_id, bus.fifo_wr_data); end
        clearReq();
    endtask

    task automatic test_random();
        for (int round = 0; round < 3; round++) begin
            doReset();
            for (int i = 0; i < NREQ; i++) begin
                int n;
                n = $urandom_range(12);
                for (int b = 0; b < n; b++)
                    pushBeat(i, WIDTH'($urandom), (b == n - 1) || ($urandom_range(99) < 25));
            end
            buildExpected();
            runTraffic(25, 20, 3000);
            nCompared++; if (timedOut || protoErr != 0) begin nMismatched++; $display("[TB] FAIL rand_protocol[%0d]: got timeout=%0b errors=%0d expected 0/0", round, timedOut, protoErr); end
            nCompared++; if (obsData.size() != expData.size()) begin nMismatched++; $display("[TB] FAIL rand_count[%0d]: got %0d writes expected %0d", round, obsData.size(), expData.size()); end
            for (int k = 0; k < expData.size() && k < obsData.size(); k++) begin
                nCompared++; if (obsData[k] !== expData[k] || obsOwn[k] != expOwn[k]) begin nMismatched++; $display("[TB] FAIL rand_beat[%0d][%0d]: got %h/p%0d expected %h/p%0d", round, k, obsData[k], obsOwn[k], expData[k], expOwn[k]); end
            end
            nCompared++; if (obsLen.size() != expLen.size()) begin nMismatched++; $display("[TB] FAIL rand_bursts[%0d]: got %0d expected %0d", round, obsLen.size(), expLen.size()); end
            for (int k = 0; k < expGrant.size() && k < obsGrant.size(); k++) begin
                nCompared++; if (obsGrant[k] != expGrant[k]) begin nMismatched++; $display("[TB] FAIL rand_order[%0d][%0d]: got %0d expected %0d", round, k, obsGrant[k], expGrant[k]); end
            end
        end
    endtask

    initial begin
        clearReq();
        bus.fifo_full = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_burst_limit();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write-side arbiter that shares one generic_fifo_sync write port between NREQ producers.
- Grants one producer at a time for a burst, which ends on a last-flagged beat or after MAX_BURST beats.
- Forwards the granted producer's beats to the FIFO with valid/ready flow control, gated by FIFO full.
- Sits directly in front of the FIFO wr_en/wr_data inputs and shares the FIFO's clk, rst_n and clr.

Parameters:
- WIDTH, 8, data width; must match the FIFO WIDTH.
- NREQ, 4, number of producers, 2..16.
- MAX_BURST, 8, maximum beats per grant, 1..255.
- ID_W, $clog2(NREQ), width of grant_id (derived).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear; same net as the FIFO clr.
- req_valid  input  NREQ  per-producer beat valid.
- req_last  input  NREQ  per-producer end-of-burst flag, qualified by req_valid.
- req_data  input  NREQ*WIDTH  producer i data in bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  beat accepted this cycle when valid & ready.
- fifo_full  input  1  FIFO full flag.
- fifo_wr_en  output  1  FIFO write strobe.
- fifo_wr_data  output  WIDTH  FIFO write data.
- grant_id  output  ID_W  current or most recent owner index.
- busy  output  1  high while in BURST.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, busy=0.
  - req_ready=0, fifo_wr_en=0, fifo_wr_data=0.
- Clear (clr high at a rising edge):
  - Same register values as reset. clr overrides every other event that cycle.
  - While clr is high, fifo_wr_en=0 and req_ready=0 combinationally, so no beat is lost or duplicated across a clear.
- State IDLE:
  - req_ready=0 and fifo_wr_en=0.
  - If any req_valid is high, select the first index at or after rr_ptr, searching upward with wrap modulo NREQ.
  - Next edge: grant_id=selected index, beat_cnt=0, state=BURST, busy=1.
  - If no req_valid is high, stay in IDLE.
- State BURST, with owner o = grant_id:
  - req_ready[o] = !fifo_full. All other req_ready bits are 0.
  - fifo_wr_en = req_valid[o] & !fifo_full.
  - fifo_wr_data = req_data[o] when fifo_wr_en is high, else 0.
  - These three outputs are combinational from registered state and the inputs; there is no added latency, so a beat is written in the same cycle it is accepted.
  - Each accepted beat increments beat_cnt (width $clog2(MAX_BURST+1)).
  - Burst terminates on an accepted beat with req_last[o]=1, or on the accepted beat that makes beat_cnt reach MAX_BURST, whichever comes first.
  - On termination: next state=IDLE, busy=0, rr_ptr=(o+1) mod NREQ, beat_cnt=0. grant_id holds its value.
  - If the owner drops req_valid mid-burst, it keeps the grant and no other producer is served. Fixed; there is no timeout.
  - If fifo_full is high, nothing is accepted and beat_cnt holds. There is no combinational path from fifo_full to state.
- Throughput: one dead IDLE cycle between consecutive bursts.
  - The FIFO is written 1 beat/cycle inside a burst while not full.
- Fairness: after a burst, the just-served producer is lowest priority.
  - With all NREQ producers requesting continuously, grants rotate 0,1,...,NREQ-1,0,...
- rr_ptr width is ID_W; wrap from NREQ-1 to 0 must hold for non-power-of-2 NREQ.
- X-safety: req_data of non-owners never reaches fifo_wr_data.

Test Plan:
- Single producer: rst_n released, req_valid[2]=1 with 3 beats 0xA1,0xA2,0xA3, last on the third. Expect:
  - IDLE one cycle, then grant_id=2, busy=1.
  - fifo_wr_en high for 3 consecutive cycles with data A1,A2,A3.
  - busy=0 after the 3rd beat; rr_ptr becomes 3.
- Fairness: NREQ=4, all producers valid, each sending 2-beat bursts with last. Expect the grant sequence 0,1,2,3,0 and 2 writes per grant. Per-producer write counts must stay equal.
- Burst limit: MAX_BURST=8, producer 1 streams 20 beats with no last. Expect 8 writes, IDLE, then regrant to 1 (only requester) for 8 more, then 4 more. The 20 beats arrive in order.
- Backpressure: during a burst, fifo_full asserted for 5 cycles after beat 2. Expect:
  - fifo_wr_en=0 and req_ready[o]=0 for those 5 cycles, with beat_cnt held at 2.
  - Resume with no lost or duplicated beat; the FIFO contents match the stimulus.
- clr mid-burst: assert clr for one cycle after beat 3 of producer 0. Expect:
  - fifo_wr_en=0 in the clr cycle; then state=IDLE, rr_ptr=0, grant_id=0.
  - The next arbitration restarts from index 0.
- Async reset mid-burst: drop rst_n between clock edges during a burst. Expect all outputs 0 immediately, without waiting for a clock edge. After release, normal arbitration resumes from rr_ptr=0.
